// File: rtl/cp0_unit.sv
// cp0_unit: MIPS Coprocessor 0 in the M stage. Holds SR (12), Cause (13), EPC (14) and PRId (15), and raises Req.
// Latency: Req and DOut are combinational in the same cycle. SR, Cause and EPC update on the next clk edge.
// Backpressure: none. Req takes priority over an mtc0 or eret in the same cycle, and that flushed write is dropped.
//
// Ports:
//   clk, reset      : clock; synchronous active-high reset
//   A1 / DOut       : mfc0 register select / combinational read data
//   A2, DIn, en     : mtc0 register select, data and write enable
//   VPC, BDIn       : victim PC and branch-delay flag of the M instruction
//   ExcCodeIn       : exception code from M (0 = none)
//   HWInt           : level-sensitive external interrupt lines
//   EXLClr          : eret in M
//   BadVAddrIn      : faulting data address (used only with CP0_BADVADDR_EN)
//   EPCOut          : EPC register, used for eret redirection
//   Req             : exception/interrupt taken this cycle
// Optional feature: define CP0_BADVADDR_EN to add BadVAddr as register 8.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2023_0701
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        en,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    input  logic [31:0] BadVAddrIn,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim_pc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    always_comb begin
        int_req   = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
        exc_req   = (ExcCodeIn != 5'd0) & ~sr_exl;
        Req       = (int_req | exc_req) & ~reset;
        // A delay-slot victim restarts at its branch. The subtraction wraps modulo 2^32.
        victim_pc = BDIn ? (VPC - 32'd4) : VPC;
        sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
        cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? 5'd0 : ExcCodeIn;
                cause_bd  <= BDIn;
                epc       <= {victim_pc[31:2], 2'b00};
            end else begin
                if (en && A2 == 5'd12) begin
                    sr_im  <= DIn[15:10];
                    sr_exl <= DIn[1];
                    sr_ie  <= DIn[0];
                end
                if (en && A2 == 5'd14) begin
                    epc <= {DIn[31:2], 2'b00};
                end
                // This assignment comes after the SR write, so eret wins over DIn[1].
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr <= 32'd0;
        end else if (Req && !int_req && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) begin
            // A misaligned fetch (AdEL with a bad PC) faults on the PC itself.
            badvaddr <= (ExcCodeIn == 5'd4 && VPC[1:0] != 2'b00) ? VPC : BadVAddrIn;
        end
    end
`else
    logic unused_badvaddr;
    assign unused_badvaddr = ^BadVAddrIn;
`endif

    always_comb begin
        DOut = 32'd0;
        case (A1)
`ifdef CP0_BADVADDR_EN
            5'd8:    DOut = badvaddr;
`endif
            5'd12:   DOut = sr_val;
            5'd13:   DOut = cause_val;
            5'd14:   DOut = epc;
            5'd15:   DOut = PRID;
            default: DOut = 32'd0;
        endcase
    end

    assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: self-checking bench for cp0_unit. Expected register reads are queued when stimulus is driven.
// Latency: expected values apply after the edge that follows the stimulus. Req is checked in the same cycle.
// Backpressure: none.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h2023_0701;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        en;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] BadVAddrIn;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;

    typedef struct {
        string       name;
        logic [4:0]  a1;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    cp0_unit #(.PRID(PRID)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .en(en),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .BadVAddrIn(BadVAddrIn), .DOut(DOut),
        .EPCOut(EPCOut), .Req(Req)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [4:0] a1, input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.a1   = a1;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic idle_inputs();
        en = 1'b0; A2 = 5'd0; DIn = 32'd0; VPC = 32'd0; BDIn = 1'b0;
        ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0; BadVAddrIn = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        HWInt = 6'h3F;
        tick();
        tick();
        push("rst_sr", 5'd12, 32'd0);
        push("rst_cause", 5'd13, 32'd0);
        push("rst_epc", 5'd14, 32'd0);
        push("rst_prid", 5'd15, PRID);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1;
            #1;
            checks++;
            if (DOut !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
            end
        end
        checks++;
        if (Req !== 1'b0) begin
            failures++;
            $display("FAIL rst_req got=%b exp=0", Req);
        end
        reset = 1'b0;
        HWInt = 6'd0;
        tick();
    endtask

    task automatic test_interrupt();
        en = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        tick();
        en = 1'b0; HWInt = 6'b000100; VPC = 32'h0000_3000;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            failures++;
            $display("FAIL int_req got=%b exp=1", Req);
        end
        push("int_sr", 5'd12, 32'h0000_FC03);
        push("int_cause", 5'd13, 32'h0000_1000);
        push("int_epc", 5'd14, 32'h0000_3000);
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1;
            #1;
            checks++;
            if (DOut !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
            end
        end
        checks++;
        if (Req !== 1'b0) begin
            failures++;
            $display("FAIL int_nested_req got=%b exp=0", Req);
        end
        HWInt = 6'd0;
    endtask

    task automatic test_exception_bd();
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; ExcCodeIn = 5'd12; BDIn = 1'b1; VPC = 32'h0000_3010;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            failures++;
            $display("FAIL ov_req got=%b exp=1", Req);
        end
        push("ov_epc", 5'd14, 32'h0000_300C);
        push("ov_cause", 5'd13, 32'h8000_0030);
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1;
            #1;
            checks++;
            if (DOut !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
            end
        end
        HWInt = 6'b000001;
        #1;
        checks++;
        if (Req !== 1'b0) begin
            failures++;
            $display("FAIL ov_held_req got=%b exp=0", Req);
        end
        HWInt = 6'd0;
        // EPC wraps below zero, and the victim PC's low bits are cleared.
        EXLClr = 1'b1; ExcCodeIn = 5'd0;
        tick();
        EXLClr = 1'b0; ExcCodeIn = 5'd12; BDIn = 1'b1; VPC = 32'h0000_0002;
        push("wrap_epcout", 5'd0, 32'hFFFF_FFFC);
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        e = sb.pop_front();
        #1;
        checks++;
        if (EPCOut !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, EPCOut, e.val);
        end
    endtask

    task automatic test_req_overrides_mtc0();
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        en = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234;
        ExcCodeIn = 5'd10; VPC = 32'h0000_4000; BDIn = 1'b0;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            failures++;
            $display("FAIL ovr_req got=%b exp=1", Req);
        end
        push("ovr_epc", 5'd14, 32'h0000_4000);
        push("ovr_cause", 5'd13, 32'h0000_0028);
        push("ovr_sr", 5'd12, 32'h0000_FC03);
        tick();
        en = 1'b0; ExcCodeIn = 5'd0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1;
            #1;
            checks++;
            if (DOut !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
            end
        end
    endtask

    task automatic test_eret_mtc0();
        HWInt = 6'b000001; EXLClr = 1'b1;
        en = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403;
        #1;
        checks++;
        if (Req !== 1'b0) begin
            failures++;
            $display("FAIL eret_req_same got=%b exp=0", Req);
        end
        push("eret_sr", 5'd12, 32'h0000_0401);
        tick();
        EXLClr = 1'b0; en = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1;
            #1;
            checks++;
            if (DOut !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
            end
        end
        checks++;
        if (Req !== 1'b1) begin
            failures++;
            $display("FAIL eret_req_next got=%b exp=1", Req);
        end
        tick();
        HWInt = 6'd0;
    endtask

    task automatic test_mtc0();
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        en = 1'b1; A2 = 5'd14; DIn = 32'h0000_5007;
        tick();
        A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        A2 = 5'd15;
        tick();
        en = 1'b0;
        push("mtc0_epc", 5'd14, 32'h0000_5004);
        push("mtc0_cause_ro", 5'd13, 32'h0000_0000);
        push("mtc0_prid_ro", 5'd15, PRID);
        push("mtc0_sr", 5'd12, 32'h0000_0401);
        push("rd_unmapped", 5'd3, 32'h0000_0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1;
            #1;
            checks++;
            if (DOut !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
            end
        end
        checks++;
        if (EPCOut !== 32'h0000_5004) begin
            failures++;
            $display("FAIL mtc0_epcout got=%h exp=00005004", EPCOut);
        end
    endtask

    task automatic test_badvaddr();
        logic [31:0] exp1;
        logic [31:0] exp2;
`ifdef CP0_BADVADDR_EN
        exp1 = 32'h0000_0013;
        exp2 = 32'h0000_5002;
`else
        exp1 = 32'h0000_0000;
        exp2 = 32'h0000_0000;
`endif
        ExcCodeIn = 5'd5; BadVAddrIn = 32'h0000_0013; VPC = 32'h0000_5000;
        push("bva_ades", 5'd8, exp1);
        tick();
        ExcCodeIn = 5'd0; BadVAddrIn = 32'd0;
        e = sb.pop_front();
        A1 = e.a1;
        #1;
        checks++;
        if (DOut !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
        end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCodeIn = 5'd4; BadVAddrIn = 32'h0000_0077; VPC = 32'h0000_5002;
        push("bva_adel_fetch", 5'd8, exp2);
        tick();
        ExcCodeIn = 5'd0; BadVAddrIn = 32'd0;
        e = sb.pop_front();
        A1 = e.a1;
        #1;
        checks++;
        if (DOut !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
        end
    endtask

    task automatic test_mid_reset();
        // EXL is 1 at this point. Reset must clear it, and Req stays low during reset.
        reset = 1'b1; ExcCodeIn = 5'd12;
        #1;
        checks++;
        if (Req !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_req got=%b exp=0", Req);
        end
        push("mid_rst_sr", 5'd12, 32'd0);
        push("mid_rst_epc", 5'd14, 32'd0);
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A1 = e.a1;
            #1;
            checks++;
            if (DOut !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.name, DOut, e.val);
            end
        end
        reset = 1'b0; ExcCodeIn = 5'd0;
        tick();
    endtask

    initial begin
        A1 = 5'd0;
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_req_overrides_mtc0();
        test_eret_mtc0();
        test_mtc0();
        test_badvaddr();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
